// File: rtl/alu_mult_seq.sv
// Unsigned N x N shift-and-add multiplier (result truncated to N bits) that
// sequences an external combinational ALU one operation per cycle.
`timescale 1ns/1ps
module alu_mult_seq #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic         o_overflow,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [2:0]   o_alu_control,
  input  logic [N-1:0] i_alu_q,
  input  logic         i_alu_mayor,
  input  logic         i_alu_paridad,
  input  logic         i_alu_zero
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] m_q, m_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] acc_q, acc_d;
  logic         lost_q, lost_d;
  logic         ovf_q, ovf_d;
  logic [N-1:0] result_q, result_d;
  logic         overflow_q, overflow_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      q_q        <= '0;
      acc_q      <= '0;
      lost_q     <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      q_q        <= q_d;
      acc_q      <= acc_d;
      lost_q     <= lost_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    m_d           = m_q;
    q_d           = q_q;
    acc_d         = acc_q;
    lost_d        = lost_q;
    ovf_d         = ovf_q;
    result_d      = result_q;
    overflow_d    = overflow_q;
    o_alu_a       = '0;
    o_alu_b       = '0;
    o_alu_control = OP_PASS;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          m_d     = i_a;
          q_d     = i_b;
          acc_d   = '0;
          lost_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        o_alu_b = q_q;
        if (i_alu_zero) begin
          // ACC is final here; loading the outputs on entry to DONE makes
          // them valid during the o_done cycle itself.
          result_d   = acc_q;
          overflow_d = ovf_q;
          state_d    = S_DONE;
        end else if (i_alu_paridad) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHL;
        end
      end
      S_ADD: begin
        o_alu_control = OP_ADD;
        o_alu_a       = acc_q;
        o_alu_b       = m_q;
        acc_d         = i_alu_q;
        if (i_alu_mayor || lost_q) begin
          ovf_d = 1'b1;
        end
        state_d = S_SHL;
      end
      S_SHL: begin
        o_alu_control = OP_SHL;
        o_alu_a       = m_q;
        m_d           = i_alu_q;
        if (m_q[N-1]) begin
          lost_d = 1'b1;
        end
        state_d = S_SHR;
      end
      S_SHR: begin
        o_alu_control = OP_SHR;
        o_alu_a       = q_q;
        q_d           = i_alu_q;
        state_d       = S_TEST;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE);
  assign o_result   = result_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: drives a 16-bit ALU model, tracks expected outputs
// with a cycle-level behavioural model, and runs directed and random multiplies.
`timescale 1ns/1ps
module tb_alu_mult_seq;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [15:0] i_a, i_b;
  logic        o_busy, o_done, o_overflow;
  logic [15:0] o_result, o_alu_a, o_alu_b;
  logic [2:0]  o_alu_control;
  logic [15:0] i_alu_q;
  logic        i_alu_mayor, i_alu_paridad, i_alu_zero;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  alu_mult_seq #(.N(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_result     (o_result),
    .o_overflow   (o_overflow),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_control(o_alu_control),
    .i_alu_q      (i_alu_q),
    .i_alu_mayor  (i_alu_mayor),
    .i_alu_paridad(i_alu_paridad),
    .i_alu_zero   (i_alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: add, shift right, shift left, pass b
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum     = {1'b0, o_alu_a} + {1'b0, o_alu_b};
    i_alu_mayor = 1'b0;
    case (o_alu_control)
      3'b000:  begin i_alu_q = alu_sum[15:0]; i_alu_mayor = alu_sum[16]; end
      3'b001:  i_alu_q = o_alu_a >> 1;
      3'b011:  i_alu_q = o_alu_a << 1;
      3'b100:  i_alu_q = o_alu_b;
      default: i_alu_q = '0;
    endcase
    i_alu_paridad = i_alu_q[0];
    i_alu_zero    = (i_alu_q == '0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [15:0] b);
    int l = 0;
    int p = 0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        l = i + 1;
        p++;
      end
    end
    return 2 + 3 * l + p;
  endfunction

  function automatic logic [31:0] prod_of(input logic [15:0] a, input logic [15:0] b);
    return {16'b0, a} * {16'b0, b};
  endfunction

  // Behavioural model: busy window, done cycle, pending and held results
  bit          m_busy;
  int          m_left;
  logic [15:0] m_res, m_pres;
  logic        m_ovf, m_povf;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
      m_ovf  <= 1'b0;
      m_pres <= '0;
      m_povf <= 1'b0;
    end else if (!m_busy) begin
      if (i_start) begin
        m_busy <= 1'b1;
        m_left <= lat_of(i_b) - 1;
        m_pres <= prod_of(i_a, i_b) & 32'hFFFF;
        m_povf <= (prod_of(i_a, i_b) >= 32'd65536);
      end
    end else if (m_left == 0) begin
      m_busy <= 1'b0;
      m_res  <= m_pres;
      m_ovf  <= m_povf;
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(o_busy), 32'(m_busy));
      check("done", 32'(o_done), 32'(m_busy && m_left == 0));
      if (m_busy && m_left == 0) begin
        check("result_at_done", 32'(o_result), 32'(m_pres));
        check("ovf_at_done", 32'(o_overflow), 32'(m_povf));
      end else begin
        check("result_held", 32'(o_result), 32'(m_res));
        check("ovf_held", 32'(o_overflow), 32'(m_ovf));
      end
      if (!m_busy) begin
        check("idle_ctrl", 32'(o_alu_control), 32'h4);
        check("idle_alu_a", 32'(o_alu_a), 32'h0);
        check("idle_alu_b", 32'(o_alu_b), 32'h0);
      end
    end
  end

  logic [2:0] ops [70];
  int         n_ops;

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (o_busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 32'(o_busy), 32'h0);
  endtask

  // Starts a multiply from IDLE; returns cycles from accept edge to o_done
  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     output int lat, output logic [15:0] res, output logic ovf);
    wait_idle();
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    lat = 0;
    n_ops = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!o_done && n_ops < 70) begin
        ops[n_ops] = o_alu_control;
        n_ops++;
      end
    end while (!o_done && lat < 200);
    if (!o_done) check("done_timeout", 32'(o_done), 32'h1);
    res = o_result;
    ovf = o_overflow;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a, b, res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs [5] = '{
    '{16'd1234, 16'h0000, 16'h0000, 1'b0, 2},
    '{16'h0000, 16'hFFFF, 16'h0000, 1'b0, 66},
    '{16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 6},
    '{16'h8000, 16'h0002, 16'h0000, 1'b1, 9},
    '{16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 66}
  };

  logic [2:0] exp_ops [12] = '{3'b100, 3'b000, 3'b011, 3'b001, 3'b100, 3'b011,
                               3'b001, 3'b100, 3'b000, 3'b011, 3'b001, 3'b100};

  initial begin
    int          lat;
    logic [15:0] res, a, b;
    logic        ovf;

    reset = 1'b1;
    i_start = 1'b0;
    i_a = '0;
    i_b = '0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_result", 32'(o_result), 32'h0);
    check("rst_ctrl", 32'(o_alu_control), 32'h4);

    run(16'd3, 16'd5, lat, res, ovf);
    check("3x5_lat", 32'(lat), 32'd13);
    check("3x5_res", 32'(res), 32'd15);
    check("3x5_ovf", 32'(ovf), 32'h0);
    check("3x5_nops", 32'(n_ops), 32'd12);
    for (int i = 0; i < 12; i++) check("3x5_op", 32'(ops[i]), 32'(exp_ops[i]));

    // Abort mid-multiply
    wait_idle();
    i_a = 16'hFFFF;
    i_b = 16'hFFFF;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(o_busy), 32'h0);
    check("abort_result", 32'(o_result), 32'h0);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(o_done), 32'h0);
    end

    foreach (vecs[i]) begin
      run(vecs[i].a, vecs[i].b, lat, res, ovf);
      check("vec_lat", 32'(lat), 32'(vecs[i].lat));
      check("vec_res", 32'(res), 32'(vecs[i].res));
      check("vec_ovf", 32'(ovf), 32'(vecs[i].ovf));
    end

    // Start held high through a run; operands change after accept
    wait_idle();
    i_a = 16'd7;
    i_b = 16'd9;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_a = 16'd5;
    i_b = 16'd6;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_done && lat < 200);
    check("spam_lat", 32'(lat), 32'd16);
    check("spam_res", 32'(o_result), 32'd63);
    @(negedge clk);
    check("spam_idle_gap", 32'(o_busy), 32'h0);
    @(posedge clk);
    #1 i_start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_done && lat < 200);
    check("b2b_lat", 32'(lat), 32'd13);
    check("b2b_res", 32'(o_result), 32'd30);
    repeat (5) @(negedge clk);
    check("b2b_held", 32'(o_result), 32'd30);

    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom) >> $urandom_range(0, 15);
      run(a, b, lat, res, ovf);
      check("rnd_lat", 32'(lat), 32'(lat_of(b)));
      check("rnd_res", 32'(res), prod_of(a, b) & 32'hFFFF);
      check("rnd_ovf", 32'(ovf), 32'(prod_of(a, b) >= 32'd65536));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
